wfid_slot_decoder: RTL

- Converts 6-bit wavefront slot IDs into one-hot form and tracks a registered 40-entry slot-occupancy mask.
- Acts as the inverse of the lowest-index slot encoder: the encoder picks a free index; this block takes issued and retired indices and decodes them back into mask bit set/clear operations.
- Sits beside the wavefront pool and dispatch logic.
- Provides occupancy count, full/empty flags and error pulses for illegal IDs.

---
 rtl/wfid_slot_decoder.sv | 71 +++++++
 1 files changed

// File: rtl/wfid_slot_decoder.sv
// wfid_slot_decoder: decodes issued/retired slot ids into a registered occupancy mask with count, flags and error pulses
module wfid_slot_decoder #(
  parameter int NUM_ENTRIES = 40,
  parameter int ID_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   set_valid,
  input  logic [ID_WIDTH-1:0]    set_id,
  input  logic                   clr_valid,
  input  logic [ID_WIDTH-1:0]    clr_id,
  output logic [NUM_ENTRIES-1:0] onehot_out,
  output logic                   onehot_valid,
  output logic [NUM_ENTRIES-1:0] mask_out,
  output logic [ID_WIDTH-1:0]    count,
  output logic                   full,
  output logic                   empty,
  output logic                   range_err,
  output logic                   state_err
);
  logic [NUM_ENTRIES-1:0] set_dec, clr_dec, mask_c, mask_n;
  logic set_in, clr_in, clr_hit, clr_bad, set_eff, set_bad;
  logic [ID_WIDTH-1:0] count_n;
  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_dec
    assign set_dec[i] = set_id == ID_WIDTH'(i);
    assign clr_dec[i] = clr_id == ID_WIDTH'(i);
  end
  // clear first, then set against the post-clear mask so same-id set+clear keeps the bit
  always_comb begin
    set_in  = |set_dec;
    clr_in  = |clr_dec;
    clr_hit = clr_valid && |(mask_out & clr_dec);
    clr_bad = clr_valid && clr_in && !clr_hit;
    mask_c  = clr_hit ? mask_out & ~clr_dec : mask_out;
    set_eff = set_valid && set_in && !(|(mask_c & set_dec));
    set_bad = set_valid && set_in && !set_eff;
    mask_n  = set_eff ? mask_c | set_dec : mask_c;
    count_n = count + ID_WIDTH'(set_eff) - ID_WIDTH'(clr_hit);
  end
  // all outputs registered; flush wins over requests, reset over everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      onehot_out   <= '0;
      onehot_valid <= 1'b0;
      mask_out     <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      range_err    <= 1'b0;
      state_err    <= 1'b0;
    end else if (flush) begin
      onehot_valid <= 1'b0;
      mask_out     <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      range_err    <= 1'b0;
      state_err    <= 1'b0;
    end else begin
      onehot_out   <= set_eff ? set_dec : onehot_out;
      onehot_valid <= set_eff;
      mask_out     <= mask_n;
      count        <= count_n;
      full         <= count_n == ID_WIDTH'(NUM_ENTRIES);
      empty        <= count_n == '0;
      range_err    <= (set_valid && !set_in) || (clr_valid && !clr_in);
      state_err    <= clr_bad || set_bad;
    end
  end
endmodule
